// File: rtl/pipe_stage_elastic_pkg.sv
// Shared definitions for the elastic pipeline stage: control-bit positions, slot
// state encoding, default MEM->WB bundle widths and the occupancy update rule.
package pipe_stage_elastic_pkg;

    localparam int CTRL_MEMTOREG = 0;
    localparam int CTRL_REGWRITE = 1;
    localparam int CTRL_IOWRITE  = 2;
    localparam int CTRL_SEGCTRL  = 3;
    localparam int CTRL_LEDCTRL  = 4;

    localparam int MEM_WB_CTRL_W = 5;
    // rd_addr[4:0], ALUResult[31:0], MemData[31:0]
    localparam int MEM_WB_DATA_W = 69;

    typedef enum logic [1:0] {
        SLOT_EMPTY = 2'd0,
        SLOT_FULL  = 2'd1,
        SLOT_SKID  = 2'd2
    } slotState_t;

    // Accept and drain in the same cycle cancel out.
    function automatic logic [3:0] occNext(input logic [3:0] occ,
                                           input logic       accepted,
                                           input logic       drained);
        case ({accepted, drained})
            2'b10:   return occ + 4'd1;
            2'b01:   return occ - 4'd1;
            default: return occ;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// One elastic slot: main register plus skid register, so the upstream ready can be
// a flop that never looks at the downstream ready in the same cycle.
module pipe_stage_elastic_slot
    import pipe_stage_elastic_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         flush,
    input  logic         inValid,
    output logic         inReady,
    input  logic [W-1:0] inPayload,
    output logic         outValid,
    input  logic         outReady,
    output logic [W-1:0] outPayload
);

    slotState_t   stateReg;
    logic [W-1:0] mainReg;
    logic [W-1:0] skidReg;
    logic         accept;
    logic         drain;

    assign accept     = inValid && inReady;
    assign drain      = outValid && outReady;
    assign outPayload = mainReg;

    // inReady and outValid are registered alongside the state so both are pure flop outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stateReg <= SLOT_EMPTY;
            mainReg  <= '0;
            skidReg  <= '0;
            inReady  <= 1'b1;
            outValid <= 1'b0;
        end else if (flush) begin
            stateReg <= SLOT_EMPTY;
            inReady  <= 1'b1;
            outValid <= 1'b0;
        end else begin
            case (stateReg)
                SLOT_EMPTY: begin
                    if (accept) begin
                        mainReg  <= inPayload;
                        stateReg <= SLOT_FULL;
                        outValid <= 1'b1;
                    end
                end
                SLOT_FULL: begin
                    if (accept && !drain) begin
                        skidReg  <= inPayload;
                        stateReg <= SLOT_SKID;
                        inReady  <= 1'b0;
                    end else if (drain && !accept) begin
                        stateReg <= SLOT_EMPTY;
                        outValid <= 1'b0;
                    end else if (accept && drain) begin
                        mainReg  <= inPayload;
                    end
                end
                SLOT_SKID: begin
                    if (drain) begin
                        mainReg  <= skidReg;
                        stateReg <= SLOT_FULL;
                        inReady  <= 1'b1;
                    end
                end
                default: begin
                    stateReg <= SLOT_EMPTY;
                    inReady  <= 1'b1;
                    outValid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: STAGES cascaded skid slots carrying a control and a data
// bundle, with flush, bubble-masked control and a beat occupancy counter.
module pipe_stage_elastic
    import pipe_stage_elastic_pkg::*;
#(
    parameter int CTRL_W    = MEM_WB_CTRL_W,
    parameter int DATA_W    = MEM_WB_DATA_W,
    parameter int STAGES    = 1,
    parameter bit ZERO_DATA = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [3:0]        occupancy
);

    localparam int W = CTRL_W + DATA_W;

    logic [STAGES-1:0] slotValid;
    logic [STAGES-1:0] slotReady;
    logic [W-1:0]      slotData [STAGES];
    logic [W-1:0]      lastPayload;
    logic [3:0]        occReg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : gSlot
            logic         upValid;
            logic [W-1:0] upData;
            logic         downReady;

            if (gi == 0) begin : gHead
                assign upValid = in_valid;
                assign upData  = {in_ctrl, in_data};
            end else begin : gChain
                assign upValid = slotValid[gi-1];
                assign upData  = slotData[gi-1];
            end

            if (gi == STAGES - 1) begin : gTail
                assign downReady = out_ready;
            end else begin : gInner
                assign downReady = slotReady[gi+1];
            end

            pipe_stage_elastic_slot #(.W(W)) uSlot (
                .clk        (clk),
                .rstn       (rstn),
                .flush      (flush),
                .inValid    (upValid),
                .inReady    (slotReady[gi]),
                .inPayload  (upData),
                .outValid   (slotValid[gi]),
                .outReady   (downReady),
                .outPayload (slotData[gi])
            );
        end
    endgenerate

    assign in_ready    = slotReady[0];
    assign out_valid   = slotValid[STAGES-1];
    assign lastPayload = slotData[STAGES-1];

    // Bubbles must never present a live RegWrite/ioWrite downstream.
    assign out_ctrl = lastPayload[W-1:DATA_W] & {CTRL_W{out_valid}};

    generate
        if (ZERO_DATA) begin : gZeroData
            assign out_data = lastPayload[DATA_W-1:0] & {DATA_W{out_valid}};
        end else begin : gHoldData
            assign out_data = lastPayload[DATA_W-1:0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occReg <= '0;
        end else if (flush) begin
            occReg <= '0;
        end else begin
            occReg <= occNext(occReg, in_valid && in_ready, out_valid && out_ready);
        end
    end

    assign occupancy = occReg;

endmodule
